// File: rtl/podule_bus_sequencer_if.sv
// Host-side podule bus: word address, access strobe, chip selects and completion.
interface podule_bus_sequencer_if #(
  parameter int NCH = 8
);
  logic [13:2]    a;
  logic           strb;
  logic [NCH-1:0] cs;
  logic           ack;
  logic           err;

  modport master (output a, strb, input cs, ack, err);
  modport slave  (input a, strb, output cs, ack, err);
endinterface

// File: rtl/podule_bus_sequencer.sv
// Podule address decoder with match/mask channel table, programmable wait
// states per channel and a one-cycle acknowledge handshake.
module podule_bus_sequencer #(
  parameter int NCH      = 8,
  parameter int SEL_BITS = 4,
  parameter int WS_BITS  = 4,
  parameter logic [NCH*SEL_BITS-1:0] CH_MATCH =
    {4'b1101, 4'b1110, 4'b1100, 4'b1011, 4'b1010, 4'b1001, 4'b1000, 4'b0000},
  parameter logic [NCH*SEL_BITS-1:0] CH_MASK =
    {4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'b1000},
  parameter logic [NCH*WS_BITS-1:0]  CH_WS = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  podule_bus_sequencer_if.slave  bus,
  input  logic                   cfg_we,
  input  logic [3:0]             cfg_ch,
  input  logic [WS_BITS-1:0]     cfg_ws
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE, HOLD} state_t;

  // Wait-state file is always 16 deep so the 4-bit cfg_ch indexes it directly.
  localparam logic [16*WS_BITS-1:0] WS_INIT = (16*WS_BITS)'(CH_WS);

  state_t               state, state_nxt;
  logic [WS_BITS-1:0]   cnt, cnt_nxt;
  logic                 miss, miss_nxt;
  logic [NCH-1:0]       cs_q, cs_nxt;
  logic                 ack_q, ack_nxt;
  logic                 err_q, err_nxt;
  logic [WS_BITS-1:0]   ws [16];

  logic [SEL_BITS-1:0]  field;
  logic [NCH-1:0]       dec_oh;
  logic                 dec_hit;
  logic [3:0]           dec_sel;

  assign field  = bus.a[13 -: SEL_BITS];
  assign bus.cs  = cs_q;
  assign bus.ack = ack_q;
  assign bus.err = err_q;

  // Lowest matching channel wins.
  always_comb begin
    dec_oh  = '0;
    dec_hit = 1'b0;
    dec_sel = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (!dec_hit &&
          ((field & CH_MASK[i*SEL_BITS +: SEL_BITS]) ==
           (CH_MATCH[i*SEL_BITS +: SEL_BITS] & CH_MASK[i*SEL_BITS +: SEL_BITS]))) begin
        dec_oh[i] = 1'b1;
        dec_hit   = 1'b1;
        dec_sel   = 4'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 16; i++) begin
        ws[i] <= WS_INIT[i*WS_BITS +: WS_BITS];
      end
    end else if (cfg_we && ({28'd0, cfg_ch} < 32'(NCH))) begin
      ws[cfg_ch] <= cfg_ws;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    miss_nxt  = miss;
    cs_nxt    = cs_q;
    ack_nxt   = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.strb) begin
          miss_nxt  = !dec_hit;
          cnt_nxt   = dec_hit ? ws[dec_sel] : '0;
          cs_nxt    = dec_oh;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (!bus.strb) begin
          cs_nxt    = '0;
          state_nxt = IDLE;
        end else if (cnt != '0) begin
          cnt_nxt = cnt - WS_BITS'(1);
        end else begin
          ack_nxt   = 1'b1;
          err_nxt   = miss;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (!bus.strb) begin
          cs_nxt    = '0;
          state_nxt = IDLE;
        end else begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (!bus.strb) begin
          cs_nxt    = '0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      miss  <= 1'b0;
      cs_q  <= '0;
      ack_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      miss  <= miss_nxt;
      cs_q  <= cs_nxt;
      ack_q <= ack_nxt;
      err_q <= err_nxt;
    end
  end

endmodule

// File: tb/tb_podule_bus_sequencer.sv
// Scoreboard bench: drivers queue expected completions, a monitor checks each ack.
module tb_podule_bus_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [13:2] a;
  logic        strb;
  logic        cfg_we;
  logic [3:0]  cfg_ch;
  logic [3:0]  cfg_ws;
  bit          which;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [7:0] cs;
    logic       err;
    int         lat;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  podule_bus_sequencer_if #(.NCH(8)) bus1 ();
  podule_bus_sequencer_if #(.NCH(8)) bus2 ();

  assign bus1.a    = a;
  assign bus1.strb = strb;
  assign bus2.a    = a;
  assign bus2.strb = strb;

  podule_bus_sequencer #(.NCH(8), .SEL_BITS(4), .WS_BITS(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_ws(cfg_ws)
  );

  // ch1 mask cleared: ch1 claims everything that ch0 does not.
  podule_bus_sequencer #(
    .NCH(8), .SEL_BITS(4), .WS_BITS(4),
    .CH_MASK({4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'b0000, 4'b1000})
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_ws(cfg_ws)
  );

  logic [7:0] mon_cs;
  logic       mon_ack, mon_err;
  assign mon_cs  = which ? bus2.cs  : bus1.cs;
  assign mon_ack = which ? bus2.ack : bus1.ack;
  assign mon_err = which ? bus2.err : bus1.err;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endfunction

  bit tracking = 0;
  bit waiting_low = 0;
  int cyc = 0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        tracking = 0; waiting_low = 0; cyc = 0;
      end else begin
        if (tracking) cyc++;
        if (mon_err) check("err_with_ack", {31'd0, mon_ack}, 1);
        if (mon_ack) begin
          if (!tracking || exp_q.size() == 0) begin
            check("unexpected_ack", 0, 1);
          end else begin
            e = exp_q.pop_front();
            check("ack_cs", {24'd0, mon_cs}, {24'd0, e.cs});
            check("ack_err", {31'd0, mon_err}, {31'd0, e.err});
            check("ack_latency", cyc - 1, e.lat);
          end
          tracking = 0; waiting_low = 1;
        end else if (tracking && !strb) begin
          tracking = 0;
        end
        if (!strb) waiting_low = 0;
        else if (!tracking && !waiting_low) begin
          tracking = 1; cyc = 0;
        end
      end
    end
  end

  task automatic cfg_write(input logic [3:0] ch, input logic [3:0] val);
    @(negedge clk);
    cfg_we = 1'b1; cfg_ch = ch; cfg_ws = val;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic access(input logic [3:0] sel, input logic [7:0] ecs, input logic eerr,
                        input int elat, input int hold, input bit mid_cfg, input bit rst_hold);
    bit got;
    exp_q.push_back('{ecs, eerr, elat});
    @(negedge clk);
    a = {sel, 8'h5A};
    strb = 1'b1;
    got = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (k == 0) begin
        check("cs_after_strb", {24'd0, mon_cs}, {24'd0, ecs});
        a = ~a;
      end
      if (mid_cfg && k == 1) begin cfg_we = 1'b1; cfg_ch = 4'd3; cfg_ws = 4'd0; end
      if (mid_cfg && k == 2) cfg_we = 1'b0;
      if (mon_ack) got = 1;
    end
    cfg_we = 1'b0;
    check("ack_seen", {31'd0, got}, 1);
    if (!got) exp_q.delete();
    if (hold == 0) strb = 1'b0;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("cs_hold", {24'd0, mon_cs}, {24'd0, ecs});
      if (h == 0) check("ack_single", {30'd0, mon_ack, mon_err}, 0);
    end
    if (rst_hold) begin
      #2 rst_n = 1'b0;
      #1;
      check("rst_cs", {24'd0, mon_cs}, 0);
      check("rst_ack", {31'd0, mon_ack}, 0);
      strb = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
    end else begin
      strb = 1'b0;
      @(negedge clk);
      check("cs_release", {24'd0, mon_cs}, 0);
      check("ack_err_low", {30'd0, mon_ack, mon_err}, 0);
    end
  endtask

  task automatic abort_access(input logic [3:0] sel, input int cycles);
    @(negedge clk);
    a = {sel, 8'h00};
    strb = 1'b1;
    repeat (cycles) @(negedge clk);
    strb = 1'b0;
    @(negedge clk);
    check("abort_cs", {24'd0, mon_cs}, 0);
    check("abort_ack", {31'd0, mon_ack}, 0);
    repeat (8) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; a = '0; strb = 1'b0;
    cfg_we = 1'b0; cfg_ch = '0; cfg_ws = '0; which = 0;
    repeat (2) @(negedge clk);
    check("rst_cs1", {24'd0, bus1.cs}, 0);
    check("rst_ackerr1", {30'd0, bus1.ack, bus1.err}, 0);
    check("rst_cs2", {24'd0, bus2.cs}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_cs", {24'd0, bus1.cs}, 0);

    access(4'b1001, 8'b0000_0100, 1'b0, 1, 0, 0, 0);
    access(4'b0110, 8'b0000_0001, 1'b0, 1, 2, 0, 0);
    cfg_write(4'd3, 4'd5);
    access(4'b1010, 8'b0000_1000, 1'b0, 6, 0, 0, 0);
    access(4'b1010, 8'b0000_1000, 1'b0, 6, 1, 1, 0);
    access(4'b1010, 8'b0000_1000, 1'b0, 1, 0, 0, 0);
    access(4'b1111, 8'b0000_0000, 1'b1, 1, 0, 0, 0);
    cfg_write(4'd1, 4'd4);
    abort_access(4'b1000, 2);
    access(4'b1000, 8'b0000_0010, 1'b0, 5, 0, 0, 0);
    cfg_write(4'd9, 4'd7);
    access(4'b1000, 8'b0000_0010, 1'b0, 5, 0, 0, 0);
    access(4'b1101, 8'b1000_0000, 1'b0, 1, 0, 0, 0);
    access(4'b1110, 8'b0100_0000, 1'b0, 1, 0, 0, 0);
    access(4'b1100, 8'b0010_0000, 1'b0, 1, 0, 0, 0);
    access(4'b1011, 8'b0001_0000, 1'b0, 1, 0, 0, 0);

    which = 1;
    access(4'b1111, 8'b0000_0010, 1'b0, 5, 0, 0, 0);
    access(4'b0011, 8'b0000_0001, 1'b0, 1, 0, 0, 0);
    access(4'b1010, 8'b0000_0010, 1'b0, 5, 0, 0, 0);

    which = 0;
    access(4'b1000, 8'b0000_0010, 1'b0, 5, 2, 0, 1);
    access(4'b1000, 8'b0000_0010, 1'b0, 1, 0, 0, 0);
    access(4'b1010, 8'b0000_1000, 1'b0, 1, 0, 0, 0);

    repeat (4) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
